// File: rtl/gf_inverse.sv
// Sequential GF(2^N) inverter: s = a^(2^N-2) mod p by square-and-multiply,
// one operation in flight, valid/ready on both sides.
module gf_inverse #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N:0]   p,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         zero_err
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_n;
  logic [N-1:0]  a_r, sq, res, sq_n, res_n;
  logic [N:0]    p_r;
  logic [CW-1:0] cnt;
  logic          accept, last;

  // Full carry-less product, then reduce from the top bit down so every bit
  // at or above N is cleared before truncation.
  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] x,
                                          input logic [N-1:0] y,
                                          input logic [N:0]   pp);
    logic [2*N-2:0] prod, pe;
    prod = '0;
    pe   = '0;
    pe[N:0] = pp;
    for (int unsigned i = 0; i < N; i++)
      if (y[i]) prod ^= ({{(N-1){1'b0}}, x} << i);
    for (int unsigned i = 2*N-2; i >= N; i--)
      if (prod[i]) prod ^= (pe << (i - N));
    return prod[N-1:0];
  endfunction

  always_comb begin
    sq_n  = gf_mul(sq, sq, p_r);
    res_n = gf_mul(res, sq_n, p_r);
  end

  always_comb begin
    accept = (state == IDLE) && in_valid;
    last   = (cnt == CW'(N - 2));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    s         = '0;
    zero_err  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        s         = res;
        zero_err  = (a_r == '0);
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // res reaches 0 naturally for a == 0, so the datapath needs no zero case.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      p_r <= '0;
      sq  <= '0;
      res <= '0;
      cnt <= '0;
    end else if (accept) begin
      a_r <= a;
      p_r <= p;
      sq  <= a;
      res <= N'(1);
      cnt <= '0;
    end else if (state == RUN) begin
      sq  <= sq_n;
      res <= res_n;
      cnt <= cnt + 1'b1;
    end
  end

endmodule
